playback_scheduler: RTL
=======================

Name: playback_scheduler

Overview:
Sequences the step-sequencer playback datapath once the input interface enters play mode. It latches BPM and loop count on a rising edge of Start and generates an exact-average-rate step tick from a phase accumulator. It advances the step index, counts completed loops, and drops play_en when the programmed loop count completes, which returns the input interface to idle. Downstream pattern memory and audio/LED drivers consume step_tick and step_idx.

Parameters:
CLK_HZ, 50000000, clock frequency in Hz; accumulator threshold THRESH = CLK_HZ*60.
NUM_STEPS, 16, steps per loop (power of 2, 2..64).
STEPS_PER_BEAT, 4, steps per beat (4 gives 16th notes).
ACC_W, 32, accumulator width; must hold THRESH + 1023*STEPS_PER_BEAT.

Ports:
CLOCK_50  in  1  system clock
nReset  in  1  asynchronous, active-low reset
Start  in  1  level from input interface; a rising edge requests playback
Stop  in  1  synchronous abort; level-sensitive
BPM  in  10  tempo in beats per minute; 0 is invalid
Loops  in  7  number of loops to play; 0 means play until Stop
Pause  in  1  freeze request; used only with PAUSE_EN
play_en  out  1  high while playing
step_tick  out  1  one-cycle pulse at each step start
step_idx  out  log2(NUM_STEPS)  current step
loop_count  out  7  completed loops in the current run
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset: state=IDLE; play_en, step_tick, done, step_idx, loop_count, acc and start_q all 0. Reset is legal at any time, including mid-run, and takes effect immediately.
- Start edge: start_q registers Start each cycle; edge = Start & ~start_q.
- IDLE:
  - On edge with BPM != 0 and Stop = 0: latch inc = BPM*STEPS_PER_BEAT and Loops.
  - Next cycle: state=RUN, play_en=1, step_tick=1, step_idx=0, loop_count=0, acc=0.
  - An edge with BPM = 0 is ignored; the block stays in IDLE.
- RUN, each cycle:
  - sum = acc + inc.
  - If sum >= THRESH: acc <= sum - THRESH and a step event occurs. Otherwise acc <= sum.
  - With inc dividing THRESH, step_tick pulses exactly THRESH/inc cycles apart, starting from the entry tick.
- Step event:
  - If step_idx != NUM_STEPS-1: step_idx+1, step_tick=1.
  - If step_idx == NUM_STEPS-1 (wrap):
    - If latched Loops != 0 and loop_count+1 == latched Loops: state=DONE, no tick.
    - Otherwise: loop_count+1 (wraps 127 to 0 silently in infinite mode), step_idx=0, step_tick=1.
- DONE, lasts 1 cycle: play_en=0, done=1, step_idx and acc cleared, loop_count holds its final value. Then IDLE.
- Stop: if asserted in RUN, next cycle is IDLE with play_en=0, step_idx=0, acc=0 and no done pulse. Stop and a step event in the same cycle: Stop wins and no tick is issued.
- BPM and Loops changes during RUN are ignored; values are latched at start.
- A Start edge during RUN or DONE is ignored. A new run requires Start to fall and rise again.
- Outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
PAUSE_EN
- Defined: Pause=1 in RUN freezes acc, step_idx and loop_count and suppresses step_tick, while play_en stays 1. On release, accumulation resumes from the frozen acc. Stop overrides Pause.
- Undefined: the Pause input is ignored and no pause logic is synthesised.

Test Plan:
All scenarios use CLK_HZ=1000, so THRESH=60000.
1. BPM=150, Loops=2, Start rises at cycle N -> play_en=1 and step_tick with idx 0 at N+1; ticks every 100 cycles; 32 ticks total; done pulse and play_en=0 at N+3201; loop_count=1 at the end.
2. BPM=0, Start rises -> state stays IDLE, play_en=0, no step_tick.
3. BPM=150, Loops=0, run 40 steps, then Stop -> step_idx wraps 15 to 0 with loop_count=1 and then 2; play_en=0 one cycle after Stop; no done pulse.
4. BPM=7 (inc=28, non-divisor) over 10 steps -> tick intervals are 2142 or 2143 cycles; their sum equals floor((60000*10 + acc_residual)/28) with no drift.
5. nReset asserted mid-run at step 5 -> all outputs are 0 immediately. After release, a new Start edge restarts cleanly from idx 0.
6. PAUSE_EN defined, Pause held 250 cycles at step 3 -> no ticks during the pause; step 4 arrives 250 cycles later than nominal.

Source files
------------

// File: rtl/playback_scheduler_if.sv
// Control and playback bus of the step-sequencer scheduler.
// The input interface drives Start/Stop/BPM/Loops/Pause; the scheduler returns play status and step timing.
interface playback_scheduler_if #(
    parameter int STEP_W = 4
);
    logic              Start;
    logic              Stop;
    logic [9:0]        BPM;
    logic [6:0]        Loops;
    logic              Pause;
    logic              play_en;
    logic              step_tick;
    logic [STEP_W-1:0] step_idx;
    logic [6:0]        loop_count;
    logic              done;

    // Level-based control with no valid/ready pairing:
    // - The master holds Start, Stop, BPM, Loops and Pause as levels.
    // - The slave samples them on every clock.
    // - Every slave output is a register.
    // - step_tick and done are single-cycle pulses.
    modport slave (
        input  Start, Stop, BPM, Loops, Pause,
        output play_en, step_tick, step_idx, loop_count, done
    );
    modport master (
        output Start, Stop, BPM, Loops, Pause,
        input  play_en, step_tick, step_idx, loop_count, done
    );
endinterface

// File: rtl/playback_scheduler.sv
// Step-sequencer playback scheduler: phase-accumulator step tick, step index and loop counting.
// Optional macro PAUSE_EN adds a Pause freeze while running.
module playback_scheduler #(
    parameter int CLK_HZ         = 50000000,
    parameter int NUM_STEPS      = 16,
    parameter int STEPS_PER_BEAT = 4,
    parameter int ACC_W          = 32
) (
    input  logic                  CLOCK_50,
    input  logic                  nReset,
    playback_scheduler_if.slave   bus,
    output logic [1:0]            state_o
);
    localparam int STEP_W = $clog2(NUM_STEPS);
    // CLK_HZ*60 exceeds 32-bit signed range at 50 MHz, so compute it in 64 bits.
    localparam logic [ACC_W-1:0]  THRESH   = ACC_W'(64'(CLK_HZ) * 64'd60);
    localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   inc_q, inc_d;
    logic [6:0]         loops_q, loops_d;
    logic [STEP_W-1:0]  idx_q, idx_d;
    logic [6:0]         lc_q, lc_d;
    logic               play_en_q, play_en_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               start_q;
    logic               start_edge;
    logic [ACC_W-1:0]   sum;
    logic               step_evt;
    logic               pause_act;

`ifdef PAUSE_EN
    assign pause_act = bus.Pause;
`else
    logic unused_pause;
    assign unused_pause = bus.Pause;
    assign pause_act    = 1'b0;
`endif

    assign start_edge = bus.Start & ~start_q;
    assign sum        = acc_q + inc_q;
    assign step_evt   = (sum >= THRESH);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        inc_d     = inc_q;
        loops_d   = loops_q;
        idx_d     = idx_q;
        lc_d      = lc_q;
        play_en_d = play_en_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                play_en_d = 1'b0;
                if (start_edge && (bus.BPM != 10'd0) && !bus.Stop) begin
                    inc_d     = ACC_W'(bus.BPM) * ACC_W'(STEPS_PER_BEAT);
                    loops_d   = bus.Loops;
                    state_d   = S_RUN;
                    play_en_d = 1'b1;
                    tick_d    = 1'b1;
                    idx_d     = '0;
                    lc_d      = '0;
                    acc_d     = '0;
                end
            end
            S_RUN: begin
                if (bus.Stop) begin
                    state_d   = S_IDLE;
                    play_en_d = 1'b0;
                    idx_d     = '0;
                    acc_d     = '0;
                end else if (!pause_act) begin
                    // Carry the residual past THRESH so the average rate is exact.
                    if (step_evt) begin
                        acc_d = sum - THRESH;
                        if (idx_q != LAST_IDX) begin
                            idx_d  = idx_q + 1'b1;
                            tick_d = 1'b1;
                        end else if ((loops_q != 7'd0) && ((lc_q + 7'd1) == loops_q)) begin
                            state_d   = S_DONE;
                            play_en_d = 1'b0;
                            done_d    = 1'b1;
                            idx_d     = '0;
                            acc_d     = '0;
                        end else begin
                            lc_d   = lc_q + 7'd1;
                            idx_d  = '0;
                            tick_d = 1'b1;
                        end
                    end else begin
                        acc_d = sum;
                    end
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                play_en_d = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                play_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            inc_q     <= '0;
            loops_q   <= '0;
            idx_q     <= '0;
            lc_q      <= '0;
            play_en_q <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            inc_q     <= inc_d;
            loops_q   <= loops_d;
            idx_q     <= idx_d;
            lc_q      <= lc_d;
            play_en_q <= play_en_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            start_q   <= bus.Start;
        end
    end

    assign bus.play_en    = play_en_q;
    assign bus.step_tick  = tick_q;
    assign bus.step_idx   = idx_q;
    assign bus.loop_count = lc_q;
    assign bus.done       = done_q;
    assign state_o        = state_q;
endmodule
